// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and control-bit masking so a bubble never commits state.
//
// Handshake: a transfer happens on a rising edge when valid and ready are both
// high in the preceding cycle. in_ready is registered and depends only on the
// occupancy after the previous edge. out_valid/out_data/out_ctrl stay stable
// while out_valid=1 and out_ready=0.
module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                main_valid;
  logic                skid_valid;
  logic [DATA_W-1:0]   main_data;
  logic [DATA_W-1:0]   skid_data;
  logic [CTRL_W-1:0]   main_ctrl;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic                in_ready_q;
  logic                in_fire;
  logic                out_fire;
  logic                load_main_in;
  logic                load_main_skid;
  logic                load_skid_in;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_valid & out_ready;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_next   = FULL;
          load_skid_in = 1'b1;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_fire && skid_valid) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush overrides everything: a concurrent in_fire is dropped, while a
    // concurrent out_fire has already been taken by the downstream stage.
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      main_valid <= (state_next != EMPTY);
      skid_valid <= (state_next == FULL);
      in_ready_q <= (state_next != FULL);
      if (flush) begin
        main_ctrl <= '0;
        skid_ctrl <= '0;
      end else begin
        if (load_main_in) begin
          main_data <= in_data;
          main_ctrl <= in_ctrl;
        end else if (load_main_skid) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
        end
        if (load_skid_in) begin
          skid_data <= in_data;
          skid_ctrl <= in_ctrl;
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a random run, checked by a
// scoreboard queue that the negedge monitor pops as entries leave the stage.
module tb_pipe_stage_reg;

  localparam int DATA_W = 101;
  localparam int CTRL_W = 8;
  localparam int W      = DATA_W + CTRL_W;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] dv(input int x);
    return DATA_W'(x);
  endfunction

  // driver
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, dv(0), '0, ordy, 1'b0);
  endtask

  // scoreboard monitor: samples mid-cycle, the values the next edge will act on
  always @(negedge clk) begin
    if (reset) begin
      chk("occ_vs_queue", W'(occupancy), W'(exp_q.size()));
      chk("in_ready", W'(in_ready), W'(exp_q.size() < 2));
      if (!out_valid) begin
        chk("bubble_ctrl", W'(out_ctrl), W'(0));
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %h expected no output at %0t", {out_ctrl, out_data}, $time);
      end else begin
        chk("out_entry", {out_ctrl, out_data}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    end
  end

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_ctrl", W'(out_ctrl), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_occ", W'(occupancy), W'(0));
    chk("rst_out_data", W'(out_data), W'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // streaming: one transfer per cycle, never using the skid entry
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, dv(i), 8'hA5, 1'b1, 1'b0);
      @(negedge clk);
      chk("stream_occ_le1", W'(occupancy <= 2'd1), W'(1));
      chk("stream_in_ready", W'(in_ready), W'(1));
      if (i > 1) chk("stream_data", W'(out_data), W'(dv(i - 1)));
    end
    idle(1'b1);
    @(negedge clk);
    chk("stream_last", {out_ctrl, out_data}, {8'hA5, dv(8)});
    idle(1'b1);
    @(negedge clk);
    chk("stream_drained", W'(out_valid), W'(0));

    // stall / skid
    drive(1'b1, dv('h10), 8'h01, 1'b0, 1'b0);
    drive(1'b1, dv('h11), 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      @(negedge clk);
      chk("stall_occ", W'(occupancy), W'(2));
      chk("stall_in_ready", W'(in_ready), W'(0));
      chk("stall_data", W'(out_data), W'(dv('h10)));
    end
    idle(1'b1);
    @(negedge clk);
    chk("skid_first", {out_ctrl, out_data}, {8'h01, dv('h10)});
    idle(1'b1);
    @(negedge clk);
    chk("skid_second", {out_ctrl, out_data}, {8'h02, dv('h11)});
    chk("skid_ready_back", W'(in_ready), W'(1));
    idle(1'b1);

    // flush while full, and flush discarding a concurrent in_fire
    drive(1'b1, dv('h30), 8'hFF, 1'b0, 1'b0);
    drive(1'b1, dv('h31), 8'hFF, 1'b0, 1'b0);
    drive(1'b1, dv('h20), 8'hFF, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk);
    chk("flush_valid", W'(out_valid), W'(0));
    chk("flush_ctrl", W'(out_ctrl), W'(0));
    chk("flush_occ", W'(occupancy), W'(0));
    drive(1'b1, dv('h40), 8'h11, 1'b0, 1'b0);
    drive(1'b1, dv('h21), 8'h12, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("flush_drop_in", W'(occupancy), W'(0));

    // bubble masking
    drive(1'b1, dv('h55), 8'h3C, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("bubble_src", {out_ctrl, out_data}, {8'h3C, dv('h55)});
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      @(negedge clk);
      chk("bubble_idle_ctrl", W'(out_ctrl), W'(0));
      chk("bubble_hold_data", W'(out_data), W'(dv('h55)));
    end

    // random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)),
            DATA_W'({$urandom, $urandom, $urandom, $urandom}),
            CTRL_W'($urandom),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 99) == 0));
    end
    repeat (3) idle(1'b1);
    @(negedge clk);
    chk("random_drained", W'(exp_q.size()), W'(0));

    // asynchronous reset mid-operation with two entries held
    drive(1'b1, dv('h61), 8'h0F, 1'b0, 1'b0);
    drive(1'b1, dv('h62), 8'hF0, 1'b0, 1'b0);
    idle(1'b0);
    #2;
    chk("pre_rst_occ", W'(occupancy), W'(2));
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_out_ctrl", W'(out_ctrl), W'(0));
    chk("arst_in_ready", W'(in_ready), W'(1));
    chk("arst_occ", W'(occupancy), W'(0));
    chk("arst_out_data", W'(out_data), W'(0));
    @(posedge clk);
    #1;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = dv('h77);
    in_ctrl   = 8'h5A;
    out_ready = 1'b1;
    idle(1'b1);
    @(negedge clk);
    chk("post_rst_accept", {out_ctrl, out_data}, {8'h5A, dv('h77)});
    idle(1'b1);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
